// File: rtl/pipeline_control_unit.sv
// Main controller for the 5-stage pipeline: Decode control bundle, Execute branch resolution,
// and a run-state FSM (warm-up, run, drain, halted) with an issued-instruction counter.
module pipeline_control_unit #(
    parameter int WIDTH         = 16,
    parameter int OPCODEWIDTH   = 4,
    parameter int WARMUP_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OPCODEWIDTH-1:0] opcodeD,
    input  logic [OPCODEWIDTH-1:0] opcodeE,
    input  logic                   NE2,
    input  logic                   ZE2,
    input  logic                   VE2,
    input  logic                   CE2,
    input  logic                   resume,
    output logic                   obtainPCAsR1DD,
    output logic                   writeEnableDD,
    output logic                   writeDataEnableMD,
    output logic                   resultSelectorWBD,
    output logic                   data2SelectorED,
    output logic [2:0]             aluControlED,
    output logic                   takeBranchE,
    output logic                   running,
    output logic                   halted,
    output logic [WIDTH-1:0]       issuedCount,
    // Debug view of the run state: 0 WARMUP, 1 RUN, 2 DRAIN, 3 HALTED.
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int CNT_MAX = (WARMUP_CYCLES > DRAIN_CYCLES) ? WARMUP_CYCLES : DRAIN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [OPCODEWIDTH-1:0] OP_NOP  = OPCODEWIDTH'(4'h0);
    localparam logic [OPCODEWIDTH-1:0] OP_HALT = OPCODEWIDTH'(4'hF);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            in_run;
    logic            branch_cond;
    logic            issue_fire;

    // The carry flag has no consumer in the current branch set.
    logic unused_carry;
    assign unused_carry = CE2;

    assign in_run    = (state == RUN);
    assign state_dbg = state;

    // Decode bundle; every state other than RUN issues a NOP.
    always_comb begin
        writeEnableDD     = 1'b0;
        writeDataEnableMD = 1'b0;
        resultSelectorWBD = 1'b0;
        data2SelectorED   = 1'b0;
        obtainPCAsR1DD    = 1'b0;
        aluControlED      = 3'b000;
        if (in_run) begin
            case (opcodeD)
                OPCODEWIDTH'(4'h1): writeEnableDD = 1'b1;
                OPCODEWIDTH'(4'h2): begin writeEnableDD = 1'b1; aluControlED = 3'b001; end
                OPCODEWIDTH'(4'h3): begin writeEnableDD = 1'b1; aluControlED = 3'b010; end
                OPCODEWIDTH'(4'h4): begin writeEnableDD = 1'b1; aluControlED = 3'b011; end
                OPCODEWIDTH'(4'h5): begin writeEnableDD = 1'b1; data2SelectorED = 1'b1; end
                OPCODEWIDTH'(4'h6): begin
                    writeEnableDD   = 1'b1;
                    data2SelectorED = 1'b1;
                    aluControlED    = 3'b001;
                end
                OPCODEWIDTH'(4'h7): begin
                    writeEnableDD     = 1'b1;
                    resultSelectorWBD = 1'b1;
                    data2SelectorED   = 1'b1;
                end
                OPCODEWIDTH'(4'h8): begin writeDataEnableMD = 1'b1; data2SelectorED = 1'b1; end
                OPCODEWIDTH'(4'h9): begin
                    writeEnableDD   = 1'b1;
                    data2SelectorED = 1'b1;
                    aluControlED    = 3'b100;
                end
                OPCODEWIDTH'(4'hA): aluControlED = 3'b001;
                OPCODEWIDTH'(4'hB), OPCODEWIDTH'(4'hC),
                OPCODEWIDTH'(4'hD), OPCODEWIDTH'(4'hE): begin
                    data2SelectorED = 1'b1;
                    obtainPCAsR1DD  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        branch_cond = 1'b0;
        case (opcodeE)
            OPCODEWIDTH'(4'hB): branch_cond = 1'b1;
            OPCODEWIDTH'(4'hC): branch_cond = ZE2;
            OPCODEWIDTH'(4'hD): branch_cond = !ZE2;
            OPCODEWIDTH'(4'hE): branch_cond = NE2 ^ VE2;
            default:            branch_cond = 1'b0;
        endcase
    end

    assign takeBranchE = branch_cond & in_run;

    // A taken branch flushes a HALT sitting in Decode, so it neither drains nor counts.
    assign issue_fire = in_run && (opcodeD != OP_NOP) && (opcodeD != OP_HALT) && !takeBranchE;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            WARMUP: begin
                if (cnt == CW'(WARMUP_CYCLES - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (opcodeD == OP_HALT && !takeBranchE) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                if (cnt == CW'(DRAIN_CYCLES - 1)) begin
                    state_next = HALTED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_next = WARMUP;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WARMUP;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= WARMUP;
            cnt         <= '0;
            running     <= 1'b0;
            halted      <= 1'b0;
            issuedCount <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            running <= (state_next == RUN);
            halted  <= (state_next == HALTED);
            if (issue_fire && issuedCount != {WIDTH{1'b1}}) begin
                issuedCount <= issuedCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed vectors, a mode/countdown model checked every
// cycle, and literal expectations at key points. A WIDTH=3 copy exercises counter saturation.
module tb_pipeline_control_unit;

    localparam int WC = 4;
    localparam int DC = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcodeD, opcodeE;
    logic       NE2, ZE2, VE2, CE2, resume;

    logic        obtainPCAsR1DD, writeEnableDD, writeDataEnableMD, resultSelectorWBD;
    logic        data2SelectorED, takeBranchE, running, halted;
    logic [2:0]  aluControlED;
    logic [15:0] issuedCount;
    logic [1:0]  state_dbg;

    logic       pc_s, we_s, wm_s, rs_s, d2_s, take_s, run_s, halt_s;
    logic [2:0] alu_s;
    logic [2:0] count_s;
    logic [1:0] state_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 warm-up, 1 run, 2 drain, 3 halted; m_left = cycles left in the timed modes.
    int m_mode   = 0;
    int m_left   = WC;
    int m_issued = 0;
    int m_issued_s = 0;

    pipeline_control_unit dut (
        .clock(clock), .reset(reset), .opcodeD(opcodeD), .opcodeE(opcodeE),
        .NE2(NE2), .ZE2(ZE2), .VE2(VE2), .CE2(CE2), .resume(resume),
        .obtainPCAsR1DD(obtainPCAsR1DD), .writeEnableDD(writeEnableDD),
        .writeDataEnableMD(writeDataEnableMD), .resultSelectorWBD(resultSelectorWBD),
        .data2SelectorED(data2SelectorED), .aluControlED(aluControlED),
        .takeBranchE(takeBranchE), .running(running), .halted(halted),
        .issuedCount(issuedCount), .state_dbg(state_dbg)
    );

    pipeline_control_unit #(.WIDTH(3)) dut_s (
        .clock(clock), .reset(reset), .opcodeD(opcodeD), .opcodeE(opcodeE),
        .NE2(NE2), .ZE2(ZE2), .VE2(VE2), .CE2(CE2), .resume(resume),
        .obtainPCAsR1DD(pc_s), .writeEnableDD(we_s),
        .writeDataEnableMD(wm_s), .resultSelectorWBD(rs_s),
        .data2SelectorED(d2_s), .aluControlED(alu_s),
        .takeBranchE(take_s), .running(run_s), .halted(halt_s),
        .issuedCount(count_s), .state_dbg(state_s)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packed as {wE, wM, rs, d2, pc, alu[2:0]}, straight from the opcode map.
    function automatic logic [7:0] dec_exp(input logic [3:0] op);
        case (op)
            4'h1: return 8'b1_0_0_0_0_000;
            4'h2: return 8'b1_0_0_0_0_001;
            4'h3: return 8'b1_0_0_0_0_010;
            4'h4: return 8'b1_0_0_0_0_011;
            4'h5: return 8'b1_0_0_1_0_000;
            4'h6: return 8'b1_0_0_1_0_001;
            4'h7: return 8'b1_0_1_1_0_000;
            4'h8: return 8'b0_1_0_1_0_000;
            4'h9: return 8'b1_0_0_1_0_100;
            4'hA: return 8'b0_0_0_0_0_001;
            4'hB, 4'hC, 4'hD, 4'hE: return 8'b0_0_0_1_1_000;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic br_exp(input logic [3:0] op, input logic n, input logic z, input logic v);
        case (op)
            4'hB: return 1'b1;
            4'hC: return z;
            4'hD: return !z;
            4'hE: return n ^ v;
            default: return 1'b0;
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model with the inputs of this cycle.
    always @(negedge clock) begin
        logic [7:0] exp_dec;
        logic       exp_take;
        logic [7:0] act_dec;
        act_dec = {writeEnableDD, writeDataEnableMD, resultSelectorWBD, data2SelectorED,
                   obtainPCAsR1DD, aluControlED};
        if (reset) begin
            m_mode = 0; m_left = WC; m_issued = 0; m_issued_s = 0;
            check("rst_decode", act_dec, 8'h00);
            check("rst_take", takeBranchE, 1'b0);
            check("rst_running", running, 1'b0);
            check("rst_halted", halted, 1'b0);
            check("rst_count", issuedCount, 16'd0);
            check("rst_state", state_dbg, 2'd0);
        end else begin
            exp_dec  = (m_mode == 1) ? dec_exp(opcodeD) : 8'h00;
            exp_take = (m_mode == 1) && br_exp(opcodeE, NE2, ZE2, VE2);
            check("decode", act_dec, exp_dec);
            check("take", takeBranchE, exp_take);
            check("running", running, m_mode == 1);
            check("halted", halted, m_mode == 3);
            check("state", state_dbg, m_mode);
            check("count", issuedCount, m_issued);
            check("count_small", count_s, m_issued_s);
            if (m_mode == 1 && opcodeD != 4'h0 && opcodeD != 4'hF && !exp_take) begin
                if (m_issued < 65535) m_issued++;
                if (m_issued_s < 7) m_issued_s++;
            end
            case (m_mode)
                0: begin m_left--; if (m_left == 0) m_mode = 1; end
                1: if (opcodeD == 4'hF && !exp_take) begin m_mode = 2; m_left = DC; end
                2: begin m_left--; if (m_left == 0) m_mode = 3; end
                default: if (resume) begin m_mode = 0; m_left = WC; end
            endcase
        end
    end

    task automatic cyc(input logic [3:0] d, input logic [3:0] e, input logic n, input logic z,
                       input logic v, input logic r, input logic res);
        @(posedge clock);
        #1;
        opcodeD = d; opcodeE = e; NE2 = n; ZE2 = z; VE2 = v; CE2 = n; reset = r; resume = res;
    endtask

    task automatic at_neg;
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; resume = 1'b0; opcodeD = 4'h0; opcodeE = 4'h0;
        NE2 = 1'b0; ZE2 = 1'b0; VE2 = 1'b0; CE2 = 1'b0;

        cyc(4'h1, 4'h0, 0, 0, 0, 1, 0);
        at_neg; check("lit_rst_we", writeEnableDD, 1'b0);

        // Warm-up: ADD held, NOP for four cycles, then issued.
        for (int i = 0; i < WC; i++) begin
            cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
            at_neg; check("lit_warm_we", writeEnableDD, 1'b0);
        end
        cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_run_we", writeEnableDD, 1'b1);
        check("lit_run_alu", aluControlED, 3'b000);
        check("lit_run_running", running, 1'b1);

        cyc(4'h7, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_load", {writeEnableDD, resultSelectorWBD, data2SelectorED, writeDataEnableMD}, 4'b1110);
        cyc(4'h8, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_store", {writeEnableDD, writeDataEnableMD, data2SelectorED}, 3'b011);

        cyc(4'h0, 4'hC, 0, 1, 0, 0, 0); at_neg; check("lit_beq_z1", takeBranchE, 1'b1);
        cyc(4'h0, 4'hC, 0, 0, 0, 0, 0); at_neg; check("lit_beq_z0", takeBranchE, 1'b0);
        cyc(4'h0, 4'hE, 1, 0, 0, 0, 0); at_neg; check("lit_blt_n1v0", takeBranchE, 1'b1);
        cyc(4'h0, 4'hE, 1, 0, 1, 0, 0); at_neg; check("lit_blt_n1v1", takeBranchE, 1'b0);
        cyc(4'h0, 4'hD, 0, 1, 0, 0, 0); at_neg; check("lit_bne_z1", takeBranchE, 1'b0);

        // Sweep every non-HALT opcode in both stages; flag bits from the opcode.
        for (int op = 0; op < 15; op++) begin
            logic [3:0] o;
            o = 4'(op);
            cyc(o, o, o[0], o[1], o[2], 0, 0);
        end

        // HALT flushed by a taken branch stays in RUN.
        cyc(4'hF, 4'hB, 0, 0, 0, 0, 0);
        at_neg; check("lit_flush_take", takeBranchE, 1'b1);
        cyc(4'h0, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_flush_running", running, 1'b1);
        check("lit_flush_halted", halted, 1'b0);

        // HALT with a not-taken BEQ drains; resume during drain is ignored.
        cyc(4'hF, 4'hC, 0, 0, 0, 0, 0);
        at_neg; check("lit_halt_seen_running", running, 1'b1);
        for (int i = 0; i < DC; i++) begin
            cyc(4'h1, 4'hB, 0, 0, 0, 0, (i == 1));
            at_neg;
            check("lit_drain_running", running, 1'b0);
            check("lit_drain_we", writeEnableDD, 1'b0);
            check("lit_drain_take", takeBranchE, 1'b0);
            check("lit_drain_halted", halted, 1'b0);
        end
        cyc(4'h1, 4'h0, 0, 0, 0, 0, 0); at_neg; check("lit_halted", halted, 1'b1);
        cyc(4'h1, 4'h0, 0, 0, 0, 0, 0); at_neg; check("lit_halted_hold", halted, 1'b1);
        cyc(4'h1, 4'h0, 0, 0, 0, 0, 1); at_neg; check("lit_resume_cycle", halted, 1'b1);
        for (int i = 0; i < WC; i++) begin
            cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
            at_neg; check("lit_rewarm_running", running, 1'b0);
        end
        cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
        at_neg; check("lit_resumed_running", running, 1'b1);

        // Fresh reset, then exactly ten issued ADDs.
        cyc(4'h0, 4'h0, 0, 0, 0, 1, 0);
        for (int i = 0; i < WC; i++) cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(4'h1, 4'h0, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_count10", issuedCount, 16'd10);
        check("lit_count_sat", count_s, 3'd7);

        // Reset in the middle of a drain.
        cyc(4'hF, 4'h0, 0, 0, 0, 0, 0);
        cyc(4'h0, 4'h0, 0, 0, 0, 0, 0);
        at_neg; check("lit_in_drain", state_dbg, 2'd2);
        cyc(4'h0, 4'h0, 0, 0, 0, 1, 0);
        at_neg;
        check("lit_middrain_count", issuedCount, 16'd0);
        check("lit_middrain_state", state_dbg, 2'd0);
        for (int i = 0; i < WC + 2; i++) cyc(4'h2, 4'h0, 0, 0, 0, 0, 0);
        at_neg;
        check("lit_final_count", issuedCount, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
